// File: rtl/ann_weight_updater.sv
// Backward-pass engine: output errors, then read-modify-write of every output weight.
// Optional hidden error terms are built when ANN_HID_DELTA_EN is defined.
module ann_weight_updater #(
    parameter int N_HID    = 5,
    parameter int N_OUT    = 3,
    parameter int DW       = 10,
    parameter int FRAC     = 6,
    parameter int LR_SHIFT = 2,
    parameter int AW       = 4
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [N_OUT*DW-1:0]   target,
    input  logic [N_OUT*DW-1:0]   out_act,
    input  logic [N_HID*DW-1:0]   hid_act,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DW-1:0]         rd_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [DW-1:0]         wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [N_HID*DW-1:0]   hid_delta
);

    localparam int XW = 2*DW+4;
    localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_OUT-1);
    localparam logic [JW-1:0] J_LAST = JW'(N_HID-1);
    localparam logic signed [XW-1:0] SMAX = {{(DW+5){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {{(DW+5){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_RD, S_UPD, S_WR, S_DONE
    } state_t;

    state_t state, nstate;

    logic [N_OUT*DW-1:0]    tgt_q, out_q;
    logic [N_HID*DW-1:0]    hid_q;
    logic signed [DW-1:0]   err_q [N_OUT];
    logic signed [DW-1:0]   err_d [N_OUT];
    logic [KW-1:0]          k_q;
    logic [JW-1:0]          j_q;
    logic                   last;
    logic [DW:0]            diff;
    logic signed [DW-1:0]   err_sel, hid_sel;
    logic signed [2*DW-1:0] prod, dw_s;
    logic signed [XW-1:0]   sum;

    function automatic logic [DW-1:0] sat_dw(input logic signed [XW-1:0] v);
        if (v > SMAX)      sat_dw = SMAX[DW-1:0];
        else if (v < SMIN) sat_dw = SMIN[DW-1:0];
        else               sat_dw = v[DW-1:0];
    endfunction

    assign last    = (k_q == K_LAST) && (j_q == J_LAST);
    assign err_sel = err_q[k_q];
    assign hid_sel = hid_q[j_q*DW +: DW];
    assign prod    = err_sel * hid_sel;
    assign dw_s    = prod >>> (FRAC + LR_SHIFT);
    assign sum     = {{(XW-DW){rd_data[DW-1]}}, rd_data}
                   + {{(XW-2*DW){dw_s[2*DW-1]}}, dw_s};

    // Saturated output error of every neuron, computed one bit wider
    always_comb begin
        diff = '0;
        for (int i = 0; i < N_OUT; i++) begin
            diff = {tgt_q[i*DW+DW-1], tgt_q[i*DW +: DW]}
                 - {out_q[i*DW+DW-1], out_q[i*DW +: DW]};
            err_d[i] = sat_dw({{(XW-DW-1){diff[DW]}}, diff});
        end
    end

    // State register
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= nstate;
    end

    // Next state and strobes
    always_comb begin
        nstate = state;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) nstate = S_ERR;
            end
            S_ERR: nstate = S_RD;
            S_RD: begin
                rd_en  = 1'b1;
                nstate = S_UPD;
            end
            S_UPD: nstate = S_WR;
            S_WR: begin
                wr_en  = 1'b1;
                nstate = last ? S_DONE : S_RD;
            end
            S_DONE: begin
                done   = 1'b1;
                nstate = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                nstate = S_IDLE;
            end
        endcase
    end

    // Input capture, error registers, indices, address and write data
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            tgt_q   <= '0;
            out_q   <= '0;
            hid_q   <= '0;
            k_q     <= '0;
            j_q     <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < N_OUT; i++) err_q[i] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        tgt_q <= target;
                        out_q <= out_act;
                        hid_q <= hid_act;
                        k_q   <= '0;
                        j_q   <= '0;
                    end
                end
                S_ERR: begin
                    for (int i = 0; i < N_OUT; i++) err_q[i] <= err_d[i];
                    rd_addr <= '0;
                end
                S_UPD: begin
                    wr_data <= sat_dw(sum);
                    wr_addr <= rd_addr;
                end
                S_WR: begin
                    if (!last) begin
                        rd_addr <= rd_addr + 1'b1;
                        if (j_q == J_LAST) begin
                            j_q <= '0;
                            k_q <= k_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ANN_HID_DELTA_EN
    logic signed [XW-1:0]   acc_q [N_HID];
    logic signed [2*DW-1:0] pacc;
    logic [N_HID*DW-1:0]    hid_delta_q;

    assign pacc      = err_sel * $signed(rd_data);
    assign hid_delta = hid_delta_q;

    // Back-propagate errors through the old weights into per-hidden accumulators
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            hid_delta_q <= '0;
            for (int j = 0; j < N_HID; j++) acc_q[j] <= '0;
        end else if (state == S_ERR) begin
            for (int j = 0; j < N_HID; j++) acc_q[j] <= '0;
        end else if (state == S_UPD) begin
            acc_q[j_q] <= acc_q[j_q] + {{(XW-2*DW){pacc[2*DW-1]}}, pacc};
        end else if (state == S_DONE) begin
            for (int j = 0; j < N_HID; j++)
                hid_delta_q[j*DW +: DW] <= sat_dw(acc_q[j] >>> FRAC);
        end
    end
`else
    assign hid_delta = '0;
`endif

endmodule

// File: tb/tb_ann_weight_updater.sv
// Scoreboard bench for ann_weight_updater with a behavioural weight store.
// Expected writes are queued at start and compared as the DUT writes.
module tb_ann_weight_updater;

    localparam int DW = 10;
    localparam int NH = 5;
    localparam int NO = 3;

    logic             Clock = 1'b0;
    logic             Rst;
    logic             start;
    logic [NO*DW-1:0] target, out_act;
    logic [NH*DW-1:0] hid_act;
    logic             rd_en, wr_en, busy, done;
    logic [3:0]       rd_addr, wr_addr;
    logic [DW-1:0]    rd_data = '0;
    logic [DW-1:0]    wr_data;
    logic [NH*DW-1:0] hid_delta;

    ann_weight_updater dut (
        .Clock(Clock), .Rst(Rst), .start(start),
        .target(target), .out_act(out_act), .hid_act(hid_act),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .hid_delta(hid_delta)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] mem [16];

    always @(posedge Clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    typedef struct { int addr; int data; } wr_t;
    wr_t sbq[$];

    int checks = 0;
    int failures = 0;
    int ref_w [16];
    int hd_exp [NH];
    int t [NO];
    int o [NO];
    int h [NH];

    task automatic check_eq(string tag, logic signed [31:0] got,
                            logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sat(int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(1023)) - 512;
    endfunction

    task automatic build_expect();
        int e [NO];
        int acc;
        for (int k = 0; k < NO; k++) e[k] = sat(t[k] - o[k]);
        for (int k = 0; k < NO; k++)
            for (int j = 0; j < NH; j++) begin
                wr_t w;
                w.addr = k*NH + j;
                w.data = sat(ref_w[w.addr] + ((e[k] * h[j]) >>> 8));
                sbq.push_back(w);
            end
        for (int j = 0; j < NH; j++) begin
            acc = 0;
            for (int k = 0; k < NO; k++) acc += e[k] * ref_w[k*NH + j];
            hd_exp[j] = sat(acc >>> 6);
        end
    endtask

    task automatic drive_inputs();
        int v;
        for (int k = 0; k < NO; k++) begin
            v = t[k]; target[k*DW +: DW] = v[DW-1:0];
            v = o[k]; out_act[k*DW +: DW] = v[DW-1:0];
        end
        for (int j = 0; j < NH; j++) begin
            v = h[j]; hid_act[j*DW +: DW] = v[DW-1:0];
        end
    endtask

    task automatic check_store();
        for (int a = 0; a < NO*NH; a++)
            check_eq($sformatf("store[%0d]", a), $signed(mem[a]), ref_w[a]);
    endtask

    task automatic run_pass(int abort_cyc, bit poke);
        wr_t w;
        bit  exp_rd, exp_wr;
        build_expect();
        @(negedge Clock);
        drive_inputs();
        start = 1'b1;
        for (int c = 0; c <= 47; c++) begin
            @(negedge Clock);
            if (c == 0) begin
                start   = 1'b0;
                target  = {$urandom, $urandom};
                out_act = {$urandom, $urandom};
                hid_act = {$urandom, $urandom};
            end
            if (c == abort_cyc) begin
                Rst = 1'b0;
                #1;
                check_eq("rst_rd_en", rd_en, 0);
                check_eq("rst_wr_en", wr_en, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_rd_addr", rd_addr, 0);
                check_eq("rst_wr_addr", wr_addr, 0);
                check_eq("rst_wr_data", wr_data, 0);
                check_eq("rst_hid_delta", (hid_delta != 0), 0);
                sbq.delete();
                repeat (2) @(negedge Clock);
                Rst = 1'b1;
                check_store();
                return;
            end
            if (poke && c == 20) start = 1'b1;
            if (poke && c == 21) start = 1'b0;
            exp_rd = (c >= 1) && (c <= 43) && ((c - 1) % 3 == 0);
            exp_wr = (c >= 3) && (c <= 45) && (c % 3 == 0);
            check_eq($sformatf("rd_en@%0d", c), rd_en, exp_rd);
            check_eq($sformatf("wr_en@%0d", c), wr_en, exp_wr);
            check_eq($sformatf("done@%0d", c), done, (c == 46));
            check_eq($sformatf("busy@%0d", c), busy, (c <= 46));
            if (rd_en)
                check_eq($sformatf("rd_addr@%0d", c), rd_addr, (c - 1) / 3);
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    check_eq("wr_extra", 1, 0);
                end else begin
                    w = sbq.pop_front();
                    ref_w[w.addr] = w.data;
                    check_eq($sformatf("wr_addr@%0d", c), wr_addr, w.addr);
                    check_eq($sformatf("wr_data@%0d", c), $signed(wr_data), w.data);
                end
            end
        end
        check_eq("sb_left", sbq.size(), 0);
        check_store();
        for (int j = 0; j < NH; j++)
`ifdef ANN_HID_DELTA_EN
            check_eq($sformatf("hid_delta[%0d]", j),
                     $signed(hid_delta[j*DW +: DW]), hd_exp[j]);
`else
            check_eq($sformatf("hid_delta[%0d]", j),
                     $signed(hid_delta[j*DW +: DW]), 0);
`endif
    endtask

    task automatic set_zero();
        for (int k = 0; k < NO; k++) begin t[k] = 0; o[k] = 0; end
        for (int j = 0; j < NH; j++) h[j] = 0;
    endtask

    task automatic set_rand();
        for (int k = 0; k < NO; k++) begin t[k] = rnd(); o[k] = rnd(); end
        for (int j = 0; j < NH; j++) h[j] = rnd();
    endtask

    task automatic load_store(int a, int v);
        mem[a]   = v[DW-1:0];
        ref_w[a] = v;
    endtask

    initial begin
        Rst = 1'b0;
        start = 1'b0;
        target = '0;
        out_act = '0;
        hid_act = '0;
        for (int a = 0; a < 16; a++) load_store(a, rnd());
        repeat (2) @(negedge Clock);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_rd_en", rd_en, 0);
        check_eq("reset_wr_en", wr_en, 0);
        check_eq("reset_wr_data", wr_data, 0);
        check_eq("reset_hid_delta", (hid_delta != 0), 0);
        Rst = 1'b1;

        set_zero();
        load_store(0, 100);
        t[0] = 64; h[0] = 64;
        run_pass(-1, 1'b0);
        check_eq("pos_weight0", ref_w[0], 116);

        set_zero();
        load_store(0, -500);
        t[0] = 0;   o[0] = 64;
        t[1] = 511; o[1] = -512;
        h[0] = 64;
        run_pass(-1, 1'b0);
        check_eq("sat_weight0", $signed(mem[0]), -512);

        set_zero();
        load_store(0, 37);
        load_store(5, 37);
        t[0] = 1; t[1] = -1; h[0] = 1;
        run_pass(-1, 1'b0);
        check_eq("floor_pos", $signed(mem[0]), 37);
        check_eq("floor_neg", $signed(mem[5]), 36);

        set_rand();
        run_pass(-1, 1'b1);

        set_rand();
        run_pass(10, 1'b0);

        set_rand();
        run_pass(-1, 1'b0);

        set_zero();
        for (int a = 0; a < NO*NH; a++) load_store(a, 64);
        for (int k = 0; k < NO; k++) t[k] = 64;
        run_pass(-1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
